// File: rtl/circle_draw_ctrl.sv
// circle_draw_ctrl: clears the framebuffer, then resets, starts and monitors the circle plotter,
// muxing both plot streams onto the single VGA write port.
module circle_draw_ctrl #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
    parameter bit          CLEAR_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    output logic       done,
    output logic       circ_rst_n,
    output logic       circ_start,
    output logic [2:0] circ_colour,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_done,
    input  logic [7:0] circ_vga_x,
    input  logic [6:0] circ_vga_y,
    input  logic [2:0] circ_vga_colour,
    input  logic       circ_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    typedef enum logic [2:0] {IDLE, CLEAR, CIRC_RST, CIRC_RUN, DONE} state_t;
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
    state_t     state, state_nx;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       clear_last, in_clear, in_run;
    assign clear_last = (cx == X_LAST) && (cy == Y_LAST);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cx            <= '0;
            cy            <= '0;
            circ_colour   <= '0;
            circ_centre_x <= '0;
            circ_centre_y <= '0;
            circ_radius   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                circ_colour   <= colour;
                circ_centre_x <= centre_x;
                circ_centre_y <= centre_y;
                circ_radius   <= radius;
                cx            <= '0;
                cy            <= '0;
            end
            // column-major scan: y inner, x outer; both wrap to 0 after the last pixel
            if (state == CLEAR) begin
                cy <= (cy == Y_LAST) ? '0 : cy + 7'd1;
                cx <= clear_last ? '0 : (cy == Y_LAST) ? cx + 8'd1 : cx;
            end
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = start ? (CLEAR_EN ? CLEAR : CIRC_RST) : IDLE;
            CLEAR:    state_nx = clear_last ? CIRC_RST : CLEAR;
            CIRC_RST: state_nx = CIRC_RUN;
            CIRC_RUN: state_nx = circ_done ? DONE : CIRC_RUN;
            DONE:     state_nx = start ? DONE : IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // outputs are forced quiet while rst_n is low so the plotter and adapter see reset immediately
    always_comb begin
        in_clear   = rst_n && (state == CLEAR);
        in_run     = rst_n && (state == CIRC_RUN);
        done       = rst_n && (state == DONE);
        circ_start = in_run;
        circ_rst_n = rst_n && (state != CIRC_RST);
        vga_x      = in_clear ? cx : in_run ? circ_vga_x : '0;
        vga_y      = in_clear ? cy : in_run ? circ_vga_y : '0;
        vga_colour = in_clear ? CLEAR_COLOUR : in_run ? circ_vga_colour : '0;
        vga_plot   = in_clear || (in_run && circ_vga_plot);
    end
endmodule

// File: tb/tb_circle_draw_ctrl.sv
// tb_circle_draw_ctrl: scoreboard bench for circle_draw_ctrl with and without the clear phase.
module tb_circle_draw_ctrl;
    logic       clk = 0, rst_n = 0, start = 0, start_z = 0;
    logic [2:0] colour = 0;
    logic [7:0] centre_x = 0, radius = 0;
    logic [6:0] centre_y = 0;
    logic       circ_done = 0, circ_vga_plot = 0;
    logic [7:0] circ_vga_x = 0;
    logic [6:0] circ_vga_y = 0;
    logic [2:0] circ_vga_colour = 0;
    logic       done, circ_rst_n, circ_start, vga_plot;
    logic [2:0] circ_colour, vga_colour;
    logic [7:0] circ_centre_x, circ_radius, vga_x;
    logic [6:0] circ_centre_y, vga_y;
    logic       done_z, circ_rst_n_z, circ_start_z, vga_plot_z;
    logic [2:0] circ_colour_z, vga_colour_z;
    logic [7:0] circ_centre_x_z, circ_radius_z, vga_x_z;
    logic [6:0] circ_centre_y_z, vga_y_z;
    int checks = 0, failures = 0;
    logic [18:0] exp_q[$];
    logic [18:0] e;

    always #5 clk = ~clk;

    circle_draw_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .colour(colour), .centre_x(centre_x),
        .centre_y(centre_y), .radius(radius), .done(done), .circ_rst_n(circ_rst_n),
        .circ_start(circ_start), .circ_colour(circ_colour), .circ_centre_x(circ_centre_x),
        .circ_centre_y(circ_centre_y), .circ_radius(circ_radius), .circ_done(circ_done),
        .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y), .circ_vga_colour(circ_vga_colour),
        .circ_vga_plot(circ_vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    circle_draw_ctrl #(.CLEAR_EN(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .colour(colour), .centre_x(centre_x),
        .centre_y(centre_y), .radius(radius), .done(done_z), .circ_rst_n(circ_rst_n_z),
        .circ_start(circ_start_z), .circ_colour(circ_colour_z), .circ_centre_x(circ_centre_x_z),
        .circ_centre_y(circ_centre_y_z), .circ_radius(circ_radius_z), .circ_done(circ_done),
        .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y), .circ_vga_colour(circ_vga_colour),
        .circ_vga_plot(circ_vga_plot), .vga_x(vga_x_z), .vga_y(vga_y_z), .vga_colour(vga_colour_z),
        .vga_plot(vga_plot_z)
    );

    task test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({done, vga_plot, vga_x, vga_y, vga_colour, circ_start, circ_rst_n} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {done, vga_plot, vga_x, vga_y, vga_colour, circ_start, circ_rst_n});
        end
        checks++;
        if ({circ_colour, circ_centre_x, circ_centre_y, circ_radius} !== 26'd0) begin
            failures++;
            $display("FAIL reset_latches got=%h exp=0", {circ_colour, circ_centre_x, circ_centre_y, circ_radius});
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({circ_rst_n, done, vga_plot, circ_start} !== 4'b1000) begin
            failures++;
            $display("FAIL idle_outputs got=%b exp=1000", {circ_rst_n, done, vga_plot, circ_start});
        end
    endtask

    task test_clear;
        colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; start = 1;
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                exp_q.push_back({1'b1, 8'(x), 7'(y), 3'b000});
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== e) begin
                failures++;
                $display("FAIL clear_pixel got=%h exp=%h", {vga_plot, vga_x, vga_y, vga_colour}, e);
            end
            @(negedge clk);
        end
        checks++;
        if ({vga_plot, circ_rst_n, circ_start} !== 3'b000) begin
            failures++;
            $display("FAIL circ_rst_cycle got=%b exp=000", {vga_plot, circ_rst_n, circ_start});
        end
        @(negedge clk);
        checks++;
        if ({circ_start, circ_rst_n} !== 2'b11) begin
            failures++;
            $display("FAIL circ_run_enter got=%b exp=11", {circ_start, circ_rst_n});
        end
        checks++;
        if ({circ_centre_x, circ_centre_y, circ_radius, circ_colour} !== {8'd80, 7'd60, 8'd40, 3'b010}) begin
            failures++;
            $display("FAIL latched_params got=%h exp=%h", {circ_centre_x, circ_centre_y, circ_radius, circ_colour},
                     {8'd80, 7'd60, 8'd40, 3'b010});
        end
    endtask

    task test_run;
        for (int i = 0; i < 50; i++) begin
            circ_vga_x = 8'(10 + i); circ_vga_y = 7'd20; circ_vga_colour = 3'b111;
            circ_vga_plot = (i != 3);
            if (i == 0) centre_x = 8'd5;
            exp_q.push_back({circ_vga_plot, circ_vga_x, circ_vga_y, circ_vga_colour});
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== e) begin
                failures++;
                $display("FAIL run_passthru got=%h exp=%h", {vga_plot, vga_x, vga_y, vga_colour}, e);
            end
            @(negedge clk);
        end
        checks++;
        if (circ_centre_x !== 8'd80) begin
            failures++;
            $display("FAIL centre_x_held got=%0d exp=80", circ_centre_x);
        end
        circ_done = 1; circ_vga_x = 8'd77; circ_vga_plot = 1;
        #1;
        checks++;
        if ({vga_plot, vga_x, circ_start} !== {1'b1, 8'd77, 1'b1}) begin
            failures++;
            $display("FAIL done_cycle_passthru got=%h exp=%h", {vga_plot, vga_x, circ_start}, {1'b1, 8'd77, 1'b1});
        end
        @(negedge clk);
        circ_done = 0;
        checks++;
        if ({done, vga_plot, circ_start} !== 3'b100) begin
            failures++;
            $display("FAIL enter_done got=%b exp=100", {done, vga_plot, circ_start});
        end
        circ_vga_plot = 0;
    endtask

    task test_back_to_back;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({done, vga_plot, circ_start} !== 3'b100) begin
                failures++;
                $display("FAIL done_hold got=%b exp=100 cyc=%0d", {done, vga_plot, circ_start}, i);
            end
        end
        start = 0; radius = 8'd10;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_release got=%b exp=0", done);
        end
        start = 1;
        @(negedge clk);
        checks++;
        if ({vga_plot, vga_x, vga_y, circ_radius} !== {1'b1, 8'd0, 7'd0, 8'd10}) begin
            failures++;
            $display("FAIL restart_clear got=%h exp=%h", {vga_plot, vga_x, vga_y, circ_radius}, {1'b1, 8'd0, 7'd0, 8'd10});
        end
    endtask

    task test_reset_mid;
        int n;
        n = 0;
        while (!(vga_x == 8'd50 && vga_y == 7'd30) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10000) begin
            failures++;
            $display("FAIL reach_50_30 got=timeout exp=pixel(50,30)");
        end
        rst_n = 0;
        #1;
        checks++;
        if ({circ_rst_n, vga_plot} !== 2'b00) begin
            failures++;
            $display("FAIL rst_same_cycle got=%b exp=00", {circ_rst_n, vga_plot});
        end
        @(negedge clk);
        checks++;
        if ({vga_plot, circ_rst_n, done, circ_start, vga_x, vga_y} !== 19'd0) begin
            failures++;
            $display("FAIL rst_mid_clear got=%h exp=0", {vga_plot, circ_rst_n, done, circ_start, vga_x, vga_y});
        end
        rst_n = 1;
        @(negedge clk);
        checks++;
        if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd0, 7'd0, 3'd0}) begin
            failures++;
            $display("FAIL fresh_clear got=%h exp=%h", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd0, 7'd0, 3'd0});
        end
        rst_n = 0; start = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task test_no_clear;
        radius = 8'd33; start_z = 1;
        @(negedge clk);
        start_z = 0;
        checks++;
        if ({circ_rst_n_z, vga_plot_z, circ_start_z, circ_radius_z} !== {3'b000, 8'd33}) begin
            failures++;
            $display("FAIL noclear_rst got=%h exp=%h", {circ_rst_n_z, vga_plot_z, circ_start_z, circ_radius_z}, {3'b000, 8'd33});
        end
        @(negedge clk);
        checks++;
        if ({circ_start_z, circ_rst_n_z} !== 2'b11) begin
            failures++;
            $display("FAIL noclear_run got=%b exp=11", {circ_start_z, circ_rst_n_z});
        end
        circ_done = 1;
        @(negedge clk);
        circ_done = 0;
        checks++;
        if (done_z !== 1'b1) begin
            failures++;
            $display("FAIL noclear_done got=%b exp=1", done_z);
        end
        @(negedge clk);
        checks++;
        if (done_z !== 1'b0) begin
            failures++;
            $display("FAIL noclear_idle got=%b exp=0", done_z);
        end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_run;
        test_back_to_back;
        test_reset_mid;
        test_no_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/circle_draw_ctrl.md
Name: circle_draw_ctrl

Overview:
- Upstream sequencer for the circle plotter. On one start request it clears the 160x120 VGA framebuffer to a fixed colour.
- It then resets, starts and monitors the circle plotter, and multiplexes the plot streams of both phases onto the single VGA adapter write port.
- It latches the draw parameters so the plotter sees stable centre, radius and colour for the whole draw.

Parameters:
- SCREEN_W, 160, framebuffer width in pixels; clear x range 0..SCREEN_W-1.
- SCREEN_H, 120, framebuffer height in pixels; clear y range 0..SCREEN_H-1.
- CLEAR_COLOUR, 3'b000, colour written during the clear phase.
- CLEAR_EN, 1, 1 = run the clear phase; 0 = go straight from IDLE to CIRC_RST.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  level request; sampled only in IDLE
- colour  in  3  circle colour
- centre_x  in  8  circle centre x
- centre_y  in  7  circle centre y
- radius  in  8  circle radius
- done  out  1  high in DONE
- circ_rst_n  out  1  reset to the circle plotter
- circ_start  out  1  run enable to the circle plotter
- circ_colour  out  3  latched colour to the plotter
- circ_centre_x  out  8  latched centre_x to the plotter
- circ_centre_y  out  7  latched centre_y to the plotter
- circ_radius  out  8  latched radius to the plotter
- circ_done  in  1  done from the circle plotter
- circ_vga_x  in  8  plotter x
- circ_vga_y  in  7  plotter y
- circ_vga_colour  in  3  plotter colour
- circ_vga_plot  in  1  plotter write strobe
- vga_x  out  8  to the VGA adapter
- vga_y  out  7  to the VGA adapter
- vga_colour  out  3  to the VGA adapter
- vga_plot  out  1  write strobe to the VGA adapter

Behaviour:
- Reset: rst_n is synchronous and active-low; clk is the clock.
  - While rst_n is low: state=IDLE; done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, circ_start=0.
  - circ_rst_n=0 while rst_n is low. Latched parameter registers = 0; clear counters = 0.
- States: IDLE, CLEAR, CIRC_RST, CIRC_RUN, DONE.
- IDLE:
  - vga_plot=0, done=0, circ_start=0, circ_rst_n=1.
  - If start=1 at a clock edge: latch colour, centre_x, centre_y and radius into the circ_* registers, and clear cx=0, cy=0.
  - Next state is CLEAR if CLEAR_EN=1, else CIRC_RST.
- CLEAR:
  - Registered outputs: vga_x=cx, vga_y=cy, vga_colour=CLEAR_COLOUR, vga_plot=1 for each cycle in this state.
  - Scan order: cy is the inner counter (0..SCREEN_H-1) and cx is the outer counter (0..SCREEN_W-1).
  - When cy=SCREEN_H-1: cy wraps to 0 and cx increments.
  - Exit: after the cycle plotting (SCREEN_W-1, SCREEN_H-1), go to CIRC_RST.
  - Timing: exactly SCREEN_W*SCREEN_H = 19200 plot cycles. The first plot (0,0) appears in the cycle after start is sampled.
  - No pixel is repeated or skipped; the counters never exceed their bounds.
- CIRC_RST:
  - Exactly 1 cycle, with circ_rst_n=0, circ_start=0 and vga_plot=0.
  - This makes the plotter reload radius and clear its state. Next state is CIRC_RUN.
- CIRC_RUN:
  - circ_start=1 and circ_rst_n=1.
  - vga_x, vga_y, vga_colour and vga_plot are a combinational pass-through of the circ_vga_* inputs, so there is no added latency.
  - When circ_done=1 is sampled, go to DONE. During that cycle, plot pass-through still applies.
- DONE:
  - done=1, vga_plot=0, circ_start=0.
  - Stays in DONE while start=1. When start=0 is sampled, return to IDLE (done drops in the next cycle).
  - A new draw therefore requires start to deassert and then reassert.
- start changes outside IDLE are ignored, except the start=0 check in DONE.
- Input changes on colour, centre_x, centre_y and radius after latching have no effect until the next IDLE->start.
- Reset mid-operation (any state): the rule in "Reset" applies on the next edge, and circ_rst_n=0 propagates to the plotter that same cycle. After rst_n=1 the block is in IDLE; any partial clear or draw is abandoned.
- vga_plot is never high in IDLE, CIRC_RST or DONE, and never high for two sources in the same cycle.
- Widths: cx is 8-bit and cy is 7-bit, unsigned; compare each against (SCREEN_W-1) and (SCREEN_H-1) respectively. There is no signed arithmetic in this block.

Test Plan:
- Reset then start=1, colour=3'b010, centre=(80,60), radius=40 -> 19200 plot cycles with colour 0, the first at (0,0), then (0,1), then (1,0) after (0,119), the last at (159,119). Then 1 cycle with circ_rst_n=0, then circ_start=1 with circ_* = 80/60/40/010.
- Stub circle model asserts circ_vga_plot with (10,20,3'b111), then circ_done after 50 cycles -> vga outputs mirror the stub in the same cycle; done=1 on the cycle after circ_done is sampled; vga_plot=0 thereafter.
- Hold start=1 in DONE for 100 cycles -> done stays 1 with no new clear. Drop start for 1 cycle, then raise with radius=10 -> new clear begins and circ_radius=10.
- Assert rst_n=0 at clear pixel (50,30) -> next cycle vga_plot=0, circ_rst_n=0, state IDLE. After release, a fresh start restarts the clear at (0,0).
- CLEAR_EN=0, start=1 -> CIRC_RST the cycle after start, with no plot cycles of CLEAR_COLOUR.
- Change centre_x from 80 to 5 during CIRC_RUN -> circ_centre_x stays 80 until the next draw.
